// File: rtl/prog_loader_ctrl_pkg.sv
// Shared project package: MIPS opcode constants plus the program loader's
// state encoding and default end-of-program marker.
package prog_loader_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE,
        DUMP_RD,
        DUMP_TX
    } loader_state_e;

endpackage

// File: rtl/prog_loader_ctrl.sv
// Program loader: assembles a byte stream into words written to instruction
// RAM, and can stream the loaded words back out byte by byte.
module prog_loader_ctrl
    import prog_loader_ctrl_pkg::*;
#(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 12,
    parameter logic [NB_DATA-1:0] HALT_WORD = NB_DATA'(DEFAULT_HALT_WORD)
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start_load,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    input  logic               i_dump_req,
    input  logic               i_tx_ready,
    output logic               o_tx_valid,
    output logic [7:0]         o_tx_data,
    input  logic [NB_ADDR-1:0] i_cpu_addr,
    output logic               o_ram_we,
    output logic [NB_ADDR-1:0] o_ram_addr,
    output logic [NB_DATA-1:0] o_ram_data,
    input  logic [NB_DATA-1:0] i_ram_data,
    output logic               o_busy,
    output logic               o_load_done,
    output logic               o_full,
    output logic [NB_ADDR-2:0] o_word_count
);

    localparam int                 NB_CNT    = NB_ADDR - 1;
    localparam logic [NB_ADDR-1:0] ADDR_STEP = NB_ADDR'(4);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = ~NB_ADDR'(3);
    localparam logic [NB_CNT-1:0]  CNT_ONE   = NB_CNT'(1);

    loader_state_e      state;
    logic [NB_ADDR-1:0] wr_ptr;
    // Read side tracked as a word index so the "words remain" test cannot
    // wrap when the RAM is completely full.
    logic [NB_CNT-1:0]  rd_idx;
    logic [NB_CNT-1:0]  rd_idx_nxt;
    logic [NB_ADDR-1:0] rd_ptr;
    logic [1:0]         byte_cnt;
    logic [1:0]         tx_cnt;
    logic [31:0]        asm_word;
    logic [31:0]        tx_shift;
    logic               ret_done;
    logic               at_last;
    logic               dump_phase;

    assign rd_idx_nxt = rd_idx + CNT_ONE;
    assign rd_ptr     = {rd_idx[NB_ADDR-3:0], 2'b00};
    assign at_last    = (wr_ptr == LAST_ADDR);
    assign dump_phase = (state == DUMP_RD) || (state == DUMP_TX);

    assign o_ram_data = NB_DATA'(asm_word);
    assign o_tx_data  = tx_shift[31:24];
    assign o_ram_addr = !o_busy    ? i_cpu_addr :
                        dump_phase ? rd_ptr     : wr_ptr;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_idx       <= '0;
            byte_cnt     <= '0;
            tx_cnt       <= '0;
            asm_word     <= '0;
            tx_shift     <= '0;
            ret_done     <= 1'b0;
            o_ram_we     <= 1'b0;
            o_tx_valid   <= 1'b0;
            o_busy       <= 1'b0;
            o_load_done  <= 1'b0;
            o_full       <= 1'b0;
            o_word_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start_load) begin
                        wr_ptr       <= '0;
                        byte_cnt     <= '0;
                        asm_word     <= '0;
                        o_word_count <= '0;
                        o_load_done  <= 1'b0;
                        o_full       <= 1'b0;
                        o_busy       <= 1'b1;
                        state        <= LOAD;
                    end else if (i_dump_req && (o_word_count != '0)) begin
                        rd_idx   <= '0;
                        ret_done <= (state == DONE);
                        o_busy   <= 1'b1;
                        state    <= DUMP_RD;
                    end
                end
                LOAD: begin
                    if (i_rx_valid) begin
                        asm_word <= {asm_word[23:0], i_rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            o_ram_we <= 1'b1;
                            state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    o_ram_we     <= 1'b0;
                    wr_ptr       <= wr_ptr + ADDR_STEP;
                    o_word_count <= o_word_count + CNT_ONE;
                    if ((NB_DATA'(asm_word) == HALT_WORD) || at_last) begin
                        o_load_done <= 1'b1;
                        o_full      <= at_last;
                        o_busy      <= 1'b0;
                        state       <= DONE;
                    end else begin
                        state <= LOAD;
                    end
                end
                DUMP_RD: begin
                    tx_shift   <= 32'(i_ram_data);
                    tx_cnt     <= '0;
                    o_tx_valid <= 1'b1;
                    state      <= DUMP_TX;
                end
                DUMP_TX: begin
                    if (i_tx_ready) begin
                        tx_shift <= {tx_shift[23:0], 8'h00};
                        tx_cnt   <= tx_cnt + 2'd1;
                        if (tx_cnt == 2'd3) begin
                            o_tx_valid <= 1'b0;
                            rd_idx     <= rd_idx_nxt;
                            if (rd_idx_nxt < o_word_count) begin
                                state <= DUMP_RD;
                            end else begin
                                o_busy <= 1'b0;
                                state  <= ret_done ? DONE : IDLE;
                            end
                        end
                    end
                end
                default: begin
                    o_ram_we   <= 1'b0;
                    o_tx_valid <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: behavioural async-read RAM, scoreboards for RAM
// writes and dumped bytes, table-driven load plus hand-written corner cases.
module tb_prog_loader_ctrl;
    import prog_loader_ctrl_pkg::*;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 12;

    logic               clk;
    logic               i_rst_n;
    logic               i_start_load;
    logic               i_rx_valid;
    logic [7:0]         i_rx_data;
    logic               i_dump_req;
    logic               i_tx_ready;
    logic               o_tx_valid;
    logic [7:0]         o_tx_data;
    logic [NB_ADDR-1:0] i_cpu_addr;
    logic               o_ram_we;
    logic [NB_ADDR-1:0] o_ram_addr;
    logic [NB_DATA-1:0] o_ram_data;
    logic [NB_DATA-1:0] i_ram_data;
    logic               o_busy;
    logic               o_load_done;
    logic               o_full;
    logic [NB_ADDR-2:0] o_word_count;

    prog_loader_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start_load(i_start_load),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .i_dump_req(i_dump_req),
        .i_tx_ready(i_tx_ready), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
        .i_cpu_addr(i_cpu_addr), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
        .o_ram_data(o_ram_data), .i_ram_data(i_ram_data), .o_busy(o_busy),
        .o_load_done(o_load_done), .o_full(o_full), .o_word_count(o_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign i_ram_data = mem[o_ram_addr[11:2]];
    always @(posedge clk) if (o_ram_we) mem[o_ram_addr[11:2]] <= o_ram_data;

    typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] word; logic [11:0] exp_addr; int exp_count; } vec_t;

    wr_t         wr_q [$];
    logic [7:0]  tx_q [$];
    int          passed = 0;
    int          total  = 0;
    int          we_seen = 0;
    logic [11:0] last_wr_addr = '0;
    logic        hold_pending = 1'b0;
    logic [7:0]  held_byte = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: RAM writes and tx handshakes sampled mid-cycle.
    always @(negedge clk) begin
        if (!i_rst_n) begin
            hold_pending <= 1'b0;
        end else begin
            if (o_ram_we) begin
                we_seen      <= we_seen + 1;
                last_wr_addr <= o_ram_addr;
                if (wr_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_write: got write 0x%0h @0x%0h, expected no write",
                             o_ram_data, o_ram_addr);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", 64'(o_ram_addr), 64'(e.addr));
                    check("wr_data", 64'(o_ram_data), 64'(e.data));
                end
            end
            if (hold_pending) begin
                check("tx_hold_valid", 64'(o_tx_valid), 64'(1));
                check("tx_hold_data", 64'(o_tx_data), 64'(held_byte));
            end
            hold_pending <= o_tx_valid && !i_tx_ready;
            held_byte    <= o_tx_data;
            if (o_tx_valid && i_tx_ready) begin
                if (tx_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_tx: got byte 0x%0h, expected no byte", o_tx_data);
                end else begin
                    check("tx_byte", 64'(o_tx_data), 64'(tx_q.pop_front()));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        i_start_load = 1'b1;
        @(posedge clk); #1;
        i_start_load = 1'b0;
    endtask

    vec_t vecs [3];

    initial begin
        int we_before;
        int cyc;
        logic [31:0] w;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        i_rst_n = 1'b0; i_start_load = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0;
        i_dump_req = 1'b0; i_tx_ready = 1'b0; i_cpu_addr = '0;

        vecs[0] = '{32'hA5A5_A5A5, 12'h000, 1};
        vecs[1] = '{32'h5A5A_5A5A, 12'h004, 2};
        vecs[2] = '{32'hFFFF_FFFF, 12'h008, 3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_we", 64'(o_ram_we), 64'(0));
        check("rst_tx_valid", 64'(o_tx_valid), 64'(0));
        check("rst_tx_data", 64'(o_tx_data), 64'(0));
        check("rst_ram_data", 64'(o_ram_data), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_load_done", 64'(o_load_done), 64'(0));
        check("rst_full", 64'(o_full), 64'(0));
        check("rst_word_count", 64'(o_word_count), 64'(0));
        i_rst_n = 1'b1;

        // Idle: CPU owns the address; dump with nothing loaded is ignored
        i_cpu_addr = 12'h00C;
        #1;
        check("idle_ram_addr", 64'(o_ram_addr), 64'(12'h00C));
        check("idle_ram_we", 64'(o_ram_we), 64'(0));
        @(posedge clk); #1; i_dump_req = 1'b1;
        @(posedge clk); #1; i_dump_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("empty_dump_busy", 64'(o_busy), 64'(0));
        check("empty_dump_state", 64'(dut.state), 64'(IDLE));
        check("empty_dump_tx_valid", 64'(o_tx_valid), 64'(0));

        // Table-driven load ending on the halt word
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back('{vecs[i].exp_addr, vecs[i].word});
            send_word(vecs[i].word);
            check("load_word_count", 64'(o_word_count), 64'(vecs[i].exp_count));
        end
        check("load_done", 64'(o_load_done), 64'(1));
        check("load_full", 64'(o_full), 64'(0));
        check("load_busy", 64'(o_busy), 64'(0));
        check("load_state", 64'(dut.state), 64'(DONE));
        check("load_wr_q_empty", 64'(wr_q.size()), 64'(0));

        // Dump back with a sink that is ready every other cycle
        for (int i = 0; i < 3; i++)
            for (int b = 3; b >= 0; b--) begin
                w = vecs[i].word;
                tx_q.push_back(w[b*8 +: 8]);
            end
        @(posedge clk); #1;
        i_dump_req = 1'b1;
        i_tx_ready = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            i_dump_req = 1'b0;
            i_tx_ready = ~i_tx_ready;
            cyc++;
        end while (!(tx_q.size() == 0 && !o_busy) && cyc < 200);
        i_tx_ready = 1'b0;
        check("dump_finished_in_time", 64'(cyc < 200), 64'(1));
        check("dump_tx_q_empty", 64'(tx_q.size()), 64'(0));
        check("dump_return_state", 64'(dut.state), 64'(DONE));
        check("dump_tx_valid_low", 64'(o_tx_valid), 64'(0));
        tx_q.delete();

        // Start and dump together in DONE: start wins
        @(posedge clk); #1;
        i_start_load = 1'b1; i_dump_req = 1'b1;
        @(posedge clk); #1;
        i_start_load = 1'b0; i_dump_req = 1'b0;
        check("both_state", 64'(dut.state), 64'(LOAD));
        check("both_busy", 64'(o_busy), 64'(1));
        check("both_word_count", 64'(o_word_count), 64'(0));
        check("both_load_done", 64'(o_load_done), 64'(0));
        check("both_full", 64'(o_full), 64'(0));
        check("both_tx_valid", 64'(o_tx_valid), 64'(0));

        // Fill the whole RAM with non-halt words
        for (int i = 0; i < 1024; i++) begin
            w = 32'h1000_0000 + 32'(i);
            wr_q.push_back('{12'(i * 4), w});
            send_word(w);
        end
        check("full_flag", 64'(o_full), 64'(1));
        check("full_word_count", 64'(o_word_count), 64'(1024));
        check("full_load_done", 64'(o_load_done), 64'(1));
        check("full_state", 64'(dut.state), 64'(DONE));
        check("full_last_addr", 64'(last_wr_addr), 64'(12'hFFC));
        check("full_wr_q_empty", 64'(wr_q.size()), 64'(0));
        we_before = we_seen;
        send_word(32'hDEAD_BEEF);
        repeat (3) @(posedge clk);
        #1;
        check("no_1025th_write", 64'(we_seen), 64'(we_before));
        check("mem_wrap_intact", 64'(mem[0]), 64'(32'h1000_0000));

        // Reset in the middle of a word
        pulse_start();
        we_before = we_seen;
        send_byte(8'h12);
        send_byte(8'h34);
        @(posedge clk); #3;
        i_rst_n = 1'b0;
        #1;
        check("midrst_state", 64'(dut.state), 64'(IDLE));
        check("midrst_busy", 64'(o_busy), 64'(0));
        check("midrst_word_count", 64'(o_word_count), 64'(0));
        check("midrst_ram_we", 64'(o_ram_we), 64'(0));
        i_rx_valid = 1'b0;
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        send_byte(8'h56);
        send_byte(8'h78);
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_write", 64'(we_seen), 64'(we_before));
        check("midrst_state_after", 64'(dut.state), 64'(IDLE));
        check("midrst_count_after", 64'(o_word_count), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
